// File: rtl/cla32_pipe_pkg.sv
// cla32_pipe_pkg: shared widths and opcode encodings for the pipelined 32-bit adder/subtractor
package cla32_pipe_pkg;
    localparam int   WIDTH  = 32;
    localparam int   HALF   = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla32_pipe_cla16.sv
// cla32_pipe_cla16: 16-bit adder of four cla4 slices with second-level group lookahead
//   i_a, i_b : 16-bit operands     i_ci : carry-in
//   o_s      : 16-bit sum          o_co : carry out of bit 15
module cla32_pipe_cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_ci,
    output logic [15:0] o_s,
    output logic        o_co
);
    logic [3:0] w_p, w_g;
    logic [3:0] w_c;
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign o_co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);
    for (genvar i = 0; i < 4; i++) begin : g_slice
        cla32_pipe_cla4 u_cla4 (
            .i_a (i_a[4*i +: 4]),
            .i_b (i_b[4*i +: 4]),
            .i_ci(w_c[i]),
            .o_s (o_s[4*i +: 4]),
            .o_p (w_p[i]),
            .o_g (w_g[i])
        );
    end
endmodule

// File: rtl/cla32_pipe_cla4.sv
// cla32_pipe_cla4: 4-bit carry-lookahead slice
//   i_a, i_b : 4-bit operands      i_ci : carry-in
//   o_s      : 4-bit sum           o_p, o_g : group propagate / generate
module cla32_pipe_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_p,
    output logic       o_g
);
    logic [3:0] w_p, w_g, w_c;
    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign o_s = w_p ^ w_c;
    assign o_p = &w_p;
    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/cla32_pipe.sv
// cla32_pipe: two-stage pipelined 32-bit add/sub with valid/ready handshake and flags
//   in_valid/in_ready, a, b, ci, op : operand beat (op 0=a+b+ci, 1=a-b)
//   out_valid/out_ready, s, co, ov, z, n : result beat with carry/overflow/zero/negative
module cla32_pipe
    import cla32_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             z,
    output logic             n
);
    logic             r_s1_valid, r_s2_valid, r_c16;
    logic [HALF-1:0]  r_lo, r_ahi, r_bhi;
    logic [WIDTH-1:0] r_s;
    logic             r_co, r_ov, r_z, r_n;
    logic             w_s1_adv, w_s2_adv, w_sub, w_cin, w_c16, w_c32, w_c31;
    logic [WIDTH-1:0] w_beff, w_sum;
    logic [HALF-1:0]  w_lo, w_hi;
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_sub    = op == OP_SUB;
    assign w_beff   = b ^ {WIDTH{w_sub}};
    assign w_cin    = w_sub ? 1'b1 : ci;
    cla32_pipe_cla16 u_lo (
        .i_a (a[HALF-1:0]),
        .i_b (w_beff[HALF-1:0]),
        .i_ci(w_cin),
        .o_s (w_lo),
        .o_co(w_c16)
    );
    cla32_pipe_cla16 u_hi (
        .i_a (r_ahi),
        .i_b (r_bhi),
        .i_ci(r_c16),
        .o_s (w_hi),
        .o_co(w_c32)
    );
    assign w_sum = {w_hi, r_lo};
    // carry into bit 31 recovered from the sum bit: s = a ^ b ^ cin
    assign w_c31 = w_hi[HALF-1] ^ r_ahi[HALF-1] ^ r_bhi[HALF-1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_c16      <= 1'b0;
            r_lo       <= '0;
            r_ahi      <= '0;
            r_bhi      <= '0;
            r_s        <= '0;
            r_co       <= 1'b0;
            r_ov       <= 1'b0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_lo  <= w_lo;
                    r_c16 <= w_c16;
                    r_ahi <= a[WIDTH-1:HALF];
                    r_bhi <= w_beff[WIDTH-1:HALF];
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s  <= w_sum;
                    r_co <= w_c32;
                    r_ov <= w_c32 ^ w_c31;
                    r_z  <= w_sum == '0;
                    r_n  <= w_sum[WIDTH-1];
                end
            end
        end
    end
    assign out_valid = r_s2_valid;
    assign s         = r_s;
    assign co        = r_co;
    assign ov        = r_ov;
    assign z         = r_z;
    assign n         = r_n;
endmodule
